// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch-stage program counter and its branch target buffer.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    // Storage width of a BTB tag/target field. The PC width may be narrower;
    // narrower values are zero-extended on write and truncated on read.
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
    } btb_entry_t;

    typedef enum logic [1:0] {
        REDIRECT,
        TRAP,
        HOLD,
        PREDICT
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: execute-stage redirect/training inputs and fetch outputs.
interface fetch_pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             ex_redirect;
    logic [WIDTH-1:0] ex_target;
    logic             ex_update;
    logic [WIDTH-1:0] ex_pc;
    logic             ex_taken;
    logic [WIDTH-1:0] ex_dest;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic             misalign;

    modport master (
        output stall, ex_redirect, ex_target, ex_update, ex_pc, ex_taken, ex_dest,
        input  pc, pc_valid, pred_taken, pred_target, misalign
    );

    modport slave (
        input  stall, ex_redirect, ex_target, ex_update, ex_pc, ex_taken, ex_dest,
        output pc, pc_valid, pred_taken, pred_target, misalign
    );
endinterface

// File: rtl/fetch_pc_unit_btb_direct_mapped.sv
// Direct-mapped branch target buffer. Addresses arrive as word addresses
// (byte address without bits [1:0]); index is the low IDX bits, tag the rest.
module btb_direct_mapped
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-3:0] lookup_word,
    output logic             hit,
    output logic [WIDTH-1:0] target,
    input  logic             upd_en,
    input  logic [WIDTH-3:0] upd_word,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_dest
);
    localparam int IDX = $clog2(DEPTH);

    btb_entry_t        mem [DEPTH];
    logic [IDX-1:0]    rd_idx;
    logic [IDX-1:0]    wr_idx;
    logic [ADDR_W-1:0] rd_tag;
    logic [ADDR_W-1:0] wr_tag;
    btb_entry_t        rd_entry;
    btb_entry_t        wr_entry;

    assign rd_idx   = lookup_word[IDX-1:0];
    assign wr_idx   = upd_word[IDX-1:0];
    assign rd_tag   = ADDR_W'(lookup_word[WIDTH-3:IDX]);
    assign wr_tag   = ADDR_W'(upd_word[WIDTH-3:IDX]);
    assign rd_entry = mem[rd_idx];
    assign wr_entry = mem[wr_idx];

    // Lookup reads the registered array, so a same-cycle write is seen next cycle.
    assign hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign target = WIDTH'(rd_entry.target);

    // Training: taken installs (overwriting any alias), not-taken evicts own tag only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: ADDR_W'(upd_dest)};
            end else if (wr_entry.tag == wr_tag) begin
                mem[wr_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: redirect > trap > stall > predicted/sequential.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               BTB_DEPTH    = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h100,
    parameter bit               BTB_EN       = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    fetch_pc_unit_if.slave     bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] btb_target;
    logic [WIDTH-1:0] pred_target;
    logic             btb_hit;
    logic             pc_valid_q;
    logic             misalign_q;
    logic             misalign_d;
    pc_sel_e          sel;

    assign seq_pc = pc_q + WIDTH'(INSTR_BYTES);

    generate
        if (BTB_EN) begin : g_btb
            btb_direct_mapped #(
                .WIDTH (WIDTH),
                .DEPTH (BTB_DEPTH)
            ) u_btb (
                .clk         (clk),
                .rst         (rst),
                .lookup_word (pc_q[WIDTH-1:2]),
                .hit         (btb_hit),
                .target      (btb_target),
                .upd_en      (bus.ex_update),
                .upd_word    (bus.ex_pc[WIDTH-1:2]),
                .upd_taken   (bus.ex_taken),
                .upd_dest    (bus.ex_dest)
            );
        end else begin : g_no_btb
            assign btb_hit    = 1'b0;
            assign btb_target = seq_pc;
        end
    endgenerate

    assign pred_target = btb_hit ? btb_target : seq_pc;

    // Source selection; the first cycle out of reset only raises pc_valid.
    always_comb begin
        sel = PREDICT;
        if (!pc_valid_q) begin
            sel = HOLD;
        end else if (bus.ex_redirect) begin
            sel = (bus.ex_target[1:0] == 2'b00) ? REDIRECT : TRAP;
        end else if (bus.stall) begin
            sel = HOLD;
        end
    end

    // Next-PC mux and the one-cycle misalign pulse.
    always_comb begin
        pc_d       = pred_target;
        misalign_d = 1'b0;
        case (sel)
            REDIRECT: pc_d = bus.ex_target;
            TRAP: begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
            end
            HOLD:     pc_d = pc_q;
            PREDICT:  pc_d = pred_target;
            default:  pc_d = pred_target;
        endcase
    end

    // PC, valid and misalign registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.pred_taken  = btb_hit;
    assign bus.pred_target = pred_target;
    assign bus.misalign    = misalign_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Parametrised next-generation program counter for the fetch stage. Adds the following to the basic PC-plus-4 and branch-target selection:
- stall hold and execute-stage redirect with fixed priority;
- a configurable reset vector;
- misaligned-target trapping;
- a direct-mapped branch target buffer (BTB) that predicts taken control flow.

It sits between the decode/execute redirect logic and instruction memory, and drives the fetch address every cycle.

Parameters:
- WIDTH, 32: address/PC width in bits.
- BTB_DEPTH, 16: number of BTB entries; power of two, at least 2.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded when a redirect target is misaligned.
- BTB_EN, 1: when 0, there is no BTB storage; pred_taken is tied to 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold the current PC (fetch back-pressure or hazard).
- ex_redirect  in  1  execute stage resolved a misprediction or jalr; load ex_target.
- ex_target  in  WIDTH  corrected next PC.
- ex_update  in  1  a resolved branch/jal is presented for BTB training.
- ex_pc  in  WIDTH  PC of the resolved instruction.
- ex_taken  in  1  resolved outcome for ex_pc.
- ex_dest  in  WIDTH  resolved taken target for ex_pc.
- pc  out  WIDTH  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- pred_taken  out  1  BTB hit for the current pc.
- pred_target  out  WIDTH  predicted target; equals pc+4 when pred_taken=0.
- misalign  out  1  one-cycle pulse: redirect target had bits[1:0]!=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VECTOR, pc_valid=0, misalign=0.
  - All BTB valid bits cleared; tag and target contents are don't-care.
- First rising edge with rst=1: pc_valid becomes 1 and stays 1 until the next reset. pc does not advance on that edge.
- BTB geometry:
  - IDX = log2(BTB_DEPTH).
  - index = addr[IDX+1:2]; tag = addr[WIDTH-1:IDX+2].
  - Each entry holds {valid, tag, target}.
- Lookup:
  - Combinational on the registered pc.
  - pred_taken = entry[index(pc)].valid AND tag matches.
  - pred_target = stored target on a hit, else pc+4.
- Next-PC priority (one-cycle latency; a new PC is visible the cycle after the edge):
  1. ex_redirect=1 with ex_target[1:0]==0: pc <= ex_target. This applies even when stall=1.
  2. ex_redirect=1 with ex_target[1:0]!=0: pc <= TRAP_VECTOR and misalign=1 for exactly one cycle.
  3. stall=1: pc holds.
  4. Otherwise: pc <= pred_target.
- Arithmetic: pc+4 is modulo 2^WIDTH. 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
- BTB training, on the edge when ex_update=1, independent of stall and redirect:
  - ex_taken=1: write entry[index(ex_pc)] = {1, tag(ex_pc), ex_dest}. This overwrites any alias.
  - ex_taken=0: clear valid only if the stored tag equals tag(ex_pc); otherwise no change.
- Same-cycle update and lookup of the same index: the lookup sees the old contents. The write is visible from the next cycle.
- Reset asserted mid-operation: immediate return to the reset state. Pending redirects and updates are discarded.
- No internal stall state: deasserting stall resumes from the held pc with a fresh lookup.
- All outputs are driven from registers, or from combinational logic of registers only. There is no input-to-output combinational path.

Decomposition:
- Package fetch_pkg holds:
  - btb_entry_t typedef (valid, tag, target);
  - the pc_sel_e enum (REDIRECT, TRAP, HOLD, PREDICT);
  - the INSTR_BYTES=4 constant.
- One natural sub-module: btb_direct_mapped.
  - Contains the storage, lookup port and training port.
  - Instantiated only when BTB_EN=1.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release.
  - Required: pc=0x0 and pc_valid=0 during reset; pc_valid=1 after the first edge; pc=0x4 after the second edge; then 0x8.
- Training and hit:
  - Stimulus: ex_update=1, ex_pc=0x10, ex_taken=1, ex_dest=0x80, then let pc run from 0.
  - Required: at pc=0x10, pred_taken=1 and pred_target=0x80; next pc=0x80.
  - Then ex_update with ex_taken=0 for 0x10: a later fetch of 0x10 gives pred_taken=0 and next pc=0x14.
- Redirect during stall: stall=1 with pc=0x20; assert ex_redirect=1 with ex_target=0x200 for one cycle.
  - Required: pc=0x200 next cycle, then holds while stall remains 1.
- Misaligned redirect: ex_redirect=1 with ex_target=0x102.
  - Required: pc=TRAP_VECTOR (0x100) and misalign=1 for exactly one cycle.
- Wrap: redirect to 0xFFFF_FFFC with an empty BTB.
  - Required: next pc=0x0000_0000.
- Alias and asynchronous reset:
  - With BTB_DEPTH=16, train 0x10→0x80, then train 0x50→0x90 (same index, different tag). Required: a fetch of 0x10 misses.
  - Then pulse rst=0 mid-run. Required: pc=0x0 immediately (asynchronously) and all BTB entries miss.
